// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared widths and state encoding for the memory access stage
package mem_access_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int CTR_W  = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - access wait counter with terminal-count flag
module mem_timeout_ctr
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CTR_W-1:0] count,
    output logic             tc
);

    // tc marks the last allowed wait cycle: a miss here makes TIMEOUT misses in total
    assign tc = (count == CTR_W'(TIMEOUT - 1));

    // Count consecutive waiting cycles; cleared whenever the stage is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CTR_W'(1);
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage issuing single data memory accesses
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_reg_write,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [DATA_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] data_out,
    output logic [REG_W-1:0]  rd_out,
    output logic              RegWrite_out,
    output logic              err_out
);

    mem_state_e       state_q;
    mem_state_e       state_d;
    logic             accept;
    logic             complete;
    logic             timeout;
    logic             is_mem;
    logic             squash;
    logic [REG_W-1:0] lat_rd;
    logic             lat_reg_write;
    logic [CTR_W-1:0] wait_count;
    logic             wait_tc;

    assign is_mem = in_mem_read | in_mem_write;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .inc   ((state_q == ACCESS) & ~dmem_ack),
        .count (wait_count),
        .tc    (wait_tc)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, stall and the accept/complete/timeout strobes
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid & is_mem & ~flush) begin
                    accept  = 1'b1;
                    stall   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    stall = 1'b1;
                    if (wait_tc) begin
                        timeout = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latching, result registers and squash tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            data_out      <= '0;
            rd_out        <= '0;
            RegWrite_out  <= 1'b0;
            err_out       <= 1'b0;
            squash        <= 1'b0;
            lat_rd        <= '0;
            lat_reg_write <= 1'b0;
        end else begin
            err_out <= 1'b0;
            case (state_q)
                IDLE: begin
                    squash <= 1'b0;
                    if (accept) begin
                        // A simultaneous read+write is issued as a write
                        dmem_req      <= 1'b1;
                        dmem_we       <= in_mem_write;
                        dmem_addr     <= in_addr;
                        dmem_wdata    <= in_wdata;
                        lat_rd        <= in_rd;
                        lat_reg_write <= in_reg_write;
                        RegWrite_out  <= 1'b0;
                    end else if (in_valid & ~flush) begin
                        data_out     <= in_addr;
                        rd_out       <= in_rd;
                        RegWrite_out <= in_reg_write;
                    end else begin
                        RegWrite_out <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (complete) begin
                        dmem_req     <= 1'b0;
                        rd_out       <= lat_rd;
                        // A flush arriving in the ack cycle squashes just like an earlier one
                        RegWrite_out <= lat_reg_write & ~dmem_we & ~squash & ~flush;
                        data_out     <= dmem_we ? dmem_addr : dmem_rdata;
                        squash       <= 1'b0;
                    end else if (timeout) begin
                        dmem_req     <= 1'b0;
                        err_out      <= 1'b1;
                        RegWrite_out <= 1'b0;
                        squash       <= 1'b0;
                    end else begin
                        RegWrite_out <= 1'b0;
                        if (flush) begin
                            squash <= 1'b1;
                        end
                    end
                end
                default: begin
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_mem_read, in_mem_write, in_reg_write;
    logic [REG_W-1:0]  in_rd;
    logic [DATA_W-1:0] in_addr, in_wdata;
    logic              flush;
    logic              dmem_req, dmem_we;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;
    logic              stall;
    logic [DATA_W-1:0] data_out;
    logic [REG_W-1:0]  rd_out;
    logic              RegWrite_out, err_out;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_mem_read  (in_mem_read),
        .in_mem_write (in_mem_write),
        .in_reg_write (in_reg_write),
        .in_rd        (in_rd),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .flush        (flush),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .stall        (stall),
        .data_out     (data_out),
        .rd_out       (rd_out),
        .RegWrite_out (RegWrite_out),
        .err_out      (err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        in_mem_read  = 1'b0;
        in_mem_write = 1'b0;
        in_reg_write = 1'b0;
        in_rd        = '0;
        in_addr      = '0;
        in_wdata     = '0;
        flush        = 1'b0;
        dmem_ack     = 1'b0;
        dmem_rdata   = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        chk("rst_data_out", data_out, 16'h0000);
        chk("rst_dmem_req", 16'(dmem_req), 16'h0);
        chk("rst_regwrite", 16'(RegWrite_out), 16'h0);
        chk("rst_err", 16'(err_out), 16'h0);
        chk("rst_stall", 16'(stall), 16'h0);
        chk("rst_dmem_addr", dmem_addr, 16'h0000);
        step();
        rst = 1'b0;

        // ALU pass-through
        in_valid = 1'b1; in_addr = 16'h1234; in_rd = 3'd5; in_reg_write = 1'b1;
        #1 chk("alu_stall_pre", 16'(stall), 16'h0);
        step();
        chk("alu_data", data_out, 16'h1234);
        chk("alu_rd", 16'(rd_out), 16'h5);
        chk("alu_rw", 16'(RegWrite_out), 16'h1);
        chk("alu_stall_post", 16'(stall), 16'h0);
        idle_inputs();
        step();
        chk("nv_rw", 16'(RegWrite_out), 16'h0);
        chk("nv_data_hold", data_out, 16'h1234);
        chk("nv_rd_hold", 16'(rd_out), 16'h5);

        // Load with 3-cycle ack latency
        in_valid = 1'b1; in_mem_read = 1'b1; in_addr = 16'h0040; in_rd = 3'd3; in_reg_write = 1'b1;
        #1 chk("ld_stall_c0", 16'(stall), 16'h1);
        chk("ld_req_c0", 16'(dmem_req), 16'h0);
        step();
        idle_inputs();
        #1 chk("ld_req_a1", 16'(dmem_req), 16'h1);
        chk("ld_we_a1", 16'(dmem_we), 16'h0);
        chk("ld_addr_a1", dmem_addr, 16'h0040);
        chk("ld_stall_a1", 16'(stall), 16'h1);
        step();
        chk("ld_req_a2", 16'(dmem_req), 16'h1);
        chk("ld_addr_a2", dmem_addr, 16'h0040);
        chk("ld_stall_a2", 16'(stall), 16'h1);
        chk("ld_rw_wait", 16'(RegWrite_out), 16'h0);
        step();
        dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
        // Store (read+write both set) presented in the ack cycle must not be taken yet
        in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b1;
        in_addr = 16'h0010; in_wdata = 16'hA5A5; in_rd = 3'd2; in_reg_write = 1'b1;
        #1 chk("ld_stall_ack", 16'(stall), 16'h0);
        chk("ld_req_ack", 16'(dmem_req), 16'h1);
        step();
        dmem_ack = 1'b0; dmem_rdata = '0;
        #1 chk("ld_data", data_out, 16'hBEEF);
        chk("ld_rd", 16'(rd_out), 16'h3);
        chk("ld_rw", 16'(RegWrite_out), 16'h1);
        chk("ld_req_done", 16'(dmem_req), 16'h0);
        chk("st_stall_accept", 16'(stall), 16'h1);

        // Store accepted one cycle after the ack, acked after one cycle
        step();
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        dmem_ack = 1'b1;
        #1 chk("st_req", 16'(dmem_req), 16'h1);
        chk("st_we", 16'(dmem_we), 16'h1);
        chk("st_wdata", dmem_wdata, 16'hA5A5);
        chk("st_addr", dmem_addr, 16'h0010);
        step();
        dmem_ack = 1'b0;
        #1 chk("st_rw", 16'(RegWrite_out), 16'h0);
        chk("st_data", data_out, 16'h0010);
        chk("st_rd", 16'(rd_out), 16'h2);
        chk("st_req_done", 16'(dmem_req), 16'h0);

        // Timeout: no ack for 15 access cycles
        idle_inputs();
        in_valid = 1'b1; in_mem_read = 1'b1; in_addr = 16'h0077; in_rd = 3'd4; in_reg_write = 1'b1;
        step();
        idle_inputs();
        for (int i = 1; i <= 15; i++) begin
            #1;
            if (dmem_req !== 1'b1 || stall !== 1'b1 || err_out !== 1'b0) begin
                chk($sformatf("to_wait_%0d", i), {13'd0, dmem_req, stall, err_out}, 16'h0006);
            end
            step();
        end
        chk("to_req", 16'(dmem_req), 16'h0);
        chk("to_err", 16'(err_out), 16'h1);
        chk("to_rw", 16'(RegWrite_out), 16'h0);
        chk("to_stall", 16'(stall), 16'h0);
        chk("to_data_hold", data_out, 16'h0010);
        step();
        chk("to_err_pulse", 16'(err_out), 16'h0);

        // Flush in the middle of a load
        in_valid = 1'b1; in_mem_read = 1'b1; in_addr = 16'h0020; in_rd = 3'd6; in_reg_write = 1'b1;
        step();
        idle_inputs();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_req_kept", 16'(dmem_req), 16'h1);
        dmem_ack = 1'b1; dmem_rdata = 16'h1111;
        step();
        dmem_ack = 1'b0;
        chk("fl_rw", 16'(RegWrite_out), 16'h0);
        chk("fl_data", data_out, 16'h1111);
        chk("fl_rd", 16'(rd_out), 16'h6);

        // Flush in IDLE suppresses the request
        in_valid = 1'b1; in_mem_read = 1'b1; in_addr = 16'h0099; in_reg_write = 1'b1; flush = 1'b1;
        #1 chk("fi_stall", 16'(stall), 16'h0);
        step();
        chk("fi_req", 16'(dmem_req), 16'h0);
        chk("fi_rw", 16'(RegWrite_out), 16'h0);

        // Ack ignored in IDLE
        idle_inputs();
        dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
        step();
        dmem_ack = 1'b0;
        chk("ia_data", data_out, 16'h1111);
        chk("ia_rw", 16'(RegWrite_out), 16'h0);

        // Reset during ACCESS
        in_valid = 1'b1; in_mem_read = 1'b1; in_addr = 16'h0055; in_rd = 3'd7; in_reg_write = 1'b1;
        step();
        idle_inputs();
        chk("ra_req", 16'(dmem_req), 16'h1);
        #2 rst = 1'b1;
        #1 chk("ra_req_rst", 16'(dmem_req), 16'h0);
        chk("ra_data_rst", data_out, 16'h0000);
        chk("ra_addr_rst", dmem_addr, 16'h0000);
        chk("ra_rd_rst", 16'(rd_out), 16'h0);
        chk("ra_stall_rst", 16'(stall), 16'h0);
        step();
        rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 16'hCAFE;
        step();
        dmem_ack = 1'b0;
        chk("ra_stray_data", data_out, 16'h0000);
        chk("ra_stray_rw", 16'(RegWrite_out), 16'h0);
        chk("ra_stray_err", 16'(err_out), 16'h0);
        step();
        chk("ra_stray_err2", 16'(err_out), 16'h0);
        chk("ra_stray_req", 16'(dmem_req), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
